// File: rtl/norm_pipe_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : norm_pipe_arbiter
// Purpose  : Round-robin scheduler sharing one sign-normalization pipeline
//            (PIPE_LAT clocks, dval in -> dval out) between NUM_REQ requesters.
//            Issues at most one RNS word per clock. Tracks the owner of every
//            in-flight word in a tag line and returns results tagged with their
//            requester ID. Flags misalignment between the pipe and the tag line.
// Ports    : clk, aclr (async, active low), en (grant enable), clr (soft clear)
//            req_valid/req_ready/req_dig     requester side
//            pipe_aclr/pipe_dval_in/pipe_dig_in,
//            pipe_dval_out/pipe_dig_out/pipe_sign   pipeline side
//            rsp_valid/rsp_id/rsp_dig/rsp_sign      result side
//            idle (nothing in flight), seq_err (sticky alignment error)
// Revision : 1.0  initial release
// ============================================================================
module norm_pipe_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_DIG  = 8,
  parameter int DIG_W    = 18,
  parameter int PIPE_LAT = 12,
  parameter int ID_W     = 2
) (
  input  logic                             clk,
  input  logic                             aclr,
  input  logic                             en,
  input  logic                             clr,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*NUM_DIG*DIG_W-1:0] req_dig,
  output logic                             pipe_aclr,
  output logic                             pipe_dval_in,
  output logic [NUM_DIG*DIG_W-1:0]         pipe_dig_in,
  input  logic                             pipe_dval_out,
  input  logic [NUM_DIG*DIG_W-1:0]         pipe_dig_out,
  input  logic [1:0]                       pipe_sign,
  output logic                             rsp_valid,
  output logic [ID_W-1:0]                  rsp_id,
  output logic [NUM_DIG*DIG_W-1:0]         rsp_dig,
  output logic [1:0]                       rsp_sign,
  output logic                             idle,
  output logic                             seq_err
);

  localparam int c_WORD_W = NUM_DIG * DIG_W;
  localparam int c_TAG_N  = PIPE_LAT + 1;
  localparam int c_CNT_W  = $clog2(PIPE_LAT + 3);
  localparam logic [c_CNT_W-1:0] c_BLANK   = c_CNT_W'(PIPE_LAT + 2);
  localparam logic [ID_W-1:0]    c_PTR_RST = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0]     r_ptr;
  logic                r_pipe_aclr;
  logic                r_pipe_dval_in;
  logic [c_WORD_W-1:0] r_pipe_dig_in;
  logic [c_TAG_N-1:0]  r_tag_v;
  logic [ID_W-1:0]     r_tag_id [c_TAG_N];
  logic [c_CNT_W-1:0]  r_cnt;
  logic [c_CNT_W-1:0]  r_blank;
  logic                r_rsp_valid;
  logic [ID_W-1:0]     r_rsp_id;
  logic [c_WORD_W-1:0] r_rsp_dig;
  logic [1:0]          r_rsp_sign;
  logic                r_seq_err;

  logic [NUM_REQ-1:0]  w_grant;
  logic [ID_W-1:0]     w_gnt_id;
  logic [ID_W-1:0]     w_cand;
  logic                w_gnt_any;
  logic                w_blank;
  logic                w_accept;
  logic                w_dec;

  // Search upward from pointer+1 with wrap; the first valid requester wins.
  always_comb begin
    w_grant   = '0;
    w_gnt_id  = '0;
    w_cand    = '0;
    w_gnt_any = 1'b0;
    if (en && !clr) begin
      for (int i = 1; i <= NUM_REQ; i++) begin
        w_cand = ID_W'((int'(r_ptr) + i) % NUM_REQ);
        if (!w_gnt_any && req_valid[w_cand]) begin
          w_gnt_any = 1'b1;
          w_gnt_id  = w_cand;
        end
      end
      if (w_gnt_any) begin
        w_grant[w_gnt_id] = 1'b1;
      end
    end
  end

  // After a soft clear the pipe may still emit stale dvals; they are masked
  // for PIPE_LAT+2 clocks so they neither respond nor raise seq_err.
  assign w_blank  = (r_blank != '0);
  assign w_accept = pipe_dval_out && !w_blank;
  assign w_dec    = r_rsp_valid && (r_cnt != '0);

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      r_ptr          <= c_PTR_RST;
      r_pipe_aclr    <= 1'b1;
      r_pipe_dval_in <= 1'b0;
      r_pipe_dig_in  <= '0;
      r_tag_v        <= '0;
      for (int k = 0; k < c_TAG_N; k++) r_tag_id[k] <= '0;
      r_cnt          <= '0;
      r_blank        <= '0;
      r_rsp_valid    <= 1'b0;
      r_rsp_id       <= '0;
      r_rsp_dig      <= '0;
      r_rsp_sign     <= 2'b00;
      r_seq_err      <= 1'b0;
    end else begin
      r_pipe_aclr <= clr;
      if (clr) begin
        r_ptr          <= c_PTR_RST;
        r_pipe_dval_in <= 1'b0;
        r_tag_v        <= '0;
        r_cnt          <= '0;
        r_blank        <= c_BLANK;
        r_rsp_valid    <= 1'b0;
        r_seq_err      <= 1'b0;
      end else begin
        r_pipe_dval_in <= w_gnt_any;
        if (w_gnt_any) begin
          r_ptr         <= w_gnt_id;
          r_pipe_dig_in <= req_dig[w_gnt_id*c_WORD_W +: c_WORD_W];
        end

        // Tag stage k is valid k clocks after pipe_dval_in; stage PIPE_LAT
        // lines up with pipe_dval_out.
        r_tag_v     <= {r_tag_v[c_TAG_N-2:0], w_gnt_any};
        r_tag_id[0] <= w_gnt_id;
        for (int k = 1; k < c_TAG_N; k++) r_tag_id[k] <= r_tag_id[k-1];

        if (w_blank) r_blank <= r_blank - 1'b1;

        r_rsp_valid <= w_accept;
        if (w_accept) begin
          r_rsp_id   <= r_tag_id[c_TAG_N-1];
          r_rsp_dig  <= pipe_dig_out;
          r_rsp_sign <= pipe_sign;
        end
        if (!w_blank && (pipe_dval_out != r_tag_v[c_TAG_N-1])) begin
          r_seq_err <= 1'b1;
        end

        if (w_gnt_any && !w_dec) begin
          r_cnt <= r_cnt + 1'b1;
        end else if (!w_gnt_any && w_dec) begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
    end
  end

  assign req_ready    = w_grant;
  assign pipe_aclr    = r_pipe_aclr;
  assign pipe_dval_in = r_pipe_dval_in;
  assign pipe_dig_in  = r_pipe_dig_in;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_id       = r_rsp_id;
  assign rsp_dig      = r_rsp_dig;
  assign rsp_sign     = r_rsp_sign;
  assign idle         = (r_cnt == '0);
  assign seq_err      = r_seq_err;

endmodule
`default_nettype wire

// File: tb/tb_norm_pipe_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_norm_pipe_arbiter
// Purpose  : Directed self-checking bench for norm_pipe_arbiter. A behavioural
//            pipe stand-in (fixed latency, digits XOR a mask, sign = low bits
//            of the input word) closes the loop; a scoreboard pairs every
//            handshake with its response.
// Revision : 1.0  initial release
// ============================================================================
module tb_norm_pipe_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int NUM_DIG  = 8;
  localparam int DIG_W    = 18;
  localparam int PIPE_LAT = 12;
  localparam int ID_W     = 2;
  localparam int WW       = NUM_DIG * DIG_W;
  localparam logic [WW-1:0] c_MASK = {8{18'h2D2D2}};

  logic                     clk;
  logic                     aclr;
  logic                     en;
  logic                     clr;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WW-1:0]    req_dig;
  logic                     pipe_aclr;
  logic                     pipe_dval_in;
  logic [WW-1:0]            pipe_dig_in;
  logic                     pipe_dval_out;
  logic [WW-1:0]            pipe_dig_out;
  logic [1:0]               pipe_sign;
  logic                     rsp_valid;
  logic [ID_W-1:0]          rsp_id;
  logic [WW-1:0]            rsp_dig;
  logic [1:0]               rsp_sign;
  logic                     idle;
  logic                     seq_err;

  norm_pipe_arbiter #(
    .NUM_REQ(NUM_REQ), .NUM_DIG(NUM_DIG), .DIG_W(DIG_W),
    .PIPE_LAT(PIPE_LAT), .ID_W(ID_W)
  ) u_dut (
    .clk(clk), .aclr(aclr), .en(en), .clr(clr),
    .req_valid(req_valid), .req_ready(req_ready), .req_dig(req_dig),
    .pipe_aclr(pipe_aclr), .pipe_dval_in(pipe_dval_in), .pipe_dig_in(pipe_dig_in),
    .pipe_dval_out(pipe_dval_out), .pipe_dig_out(pipe_dig_out), .pipe_sign(pipe_sign),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_dig(rsp_dig), .rsp_sign(rsp_sign),
    .idle(idle), .seq_err(seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural pipe stand-in ----------------
  logic                pipe_early;
  logic [PIPE_LAT-1:0] pv;
  logic [WW-1:0]       pd [PIPE_LAT];
  logic [WW-1:0]       p_tap;

  always @(posedge clk) begin
    if (pipe_aclr) begin
      pv <= '0;
      for (int k = 0; k < PIPE_LAT; k++) pd[k] <= '0;
    end else begin
      pv    <= {pv[PIPE_LAT-2:0], pipe_dval_in};
      pd[0] <= pipe_dig_in;
      for (int k = 1; k < PIPE_LAT; k++) pd[k] <= pd[k-1];
    end
  end

  assign p_tap         = pipe_early ? pd[PIPE_LAT-2] : pd[PIPE_LAT-1];
  assign pipe_dval_out = pipe_early ? pv[PIPE_LAT-2] : pv[PIPE_LAT-1];
  assign pipe_dig_out  = p_tap ^ c_MASK;
  assign pipe_sign     = p_tap[1:0];

  // ---------------- scoreboard / monitor ----------------
  typedef struct {
    int            cyc;
    int            id;
    logic [WW-1:0] w;
  } ent_t;

  ent_t       sb_q [$];
  logic [1:0] sign_log [$];
  int         cyc = 0;
  int         rsp_cnt = 0;
  int         last_rsp_cyc = 0;
  bit         sb_off = 1'b0;

  always @(negedge clk) begin
    ent_t e;
    cyc++;
    if (!aclr || clr) begin
      sb_q.delete();
    end else begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if (req_valid[r] && req_ready[r]) begin
          e.cyc = cyc;
          e.id  = r;
          e.w   = req_dig[r*WW +: WW];
          sb_q.push_back(e);
        end
      end
      if (rsp_valid) begin
        rsp_cnt++;
        last_rsp_cyc = cyc;
        sign_log.push_back(rsp_sign);
        if (!sb_off) begin
          if (sb_q.size() == 0) begin
            check("rsp_unexpected", 1, 0);
          end else begin
            e = sb_q.pop_front();
            check("rsp_id", rsp_id, e.id);
            check("rsp_dig", rsp_dig, e.w ^ c_MASK);
            check("rsp_sign", rsp_sign, e.w[1:0]);
            check("rsp_latency", cyc - e.cyc, PIPE_LAT + 2);
          end
        end
      end
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [WW-1:0] mk(input logic [17:0] d0, d1, d2, d3, d4, d5, d6, d7);
    return {d7, d6, d5, d4, d3, d2, d1, d0};
  endfunction

  function automatic logic [WW-1:0] rrw(input int r, input int n);
    return {8{18'(r * 37 + n * 5 + 1)}};
  endfunction

  task automatic chk_reset_outputs(input string tag);
    check({tag, "_ready"}, req_ready, 0);
    check({tag, "_dval_in"}, pipe_dval_in, 0);
    check({tag, "_dig_in"}, pipe_dig_in, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_id"}, rsp_id, 0);
    check({tag, "_rsp_dig"}, rsp_dig, 0);
    check({tag, "_rsp_sign"}, rsp_sign, 0);
    check({tag, "_idle"}, idle, 1);
    check({tag, "_seq_err"}, seq_err, 0);
    check({tag, "_pipe_aclr"}, pipe_aclr, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    aclr = 1'b0; req_valid = '0; en = 1'b1; clr = 1'b0;
    repeat (2) @(negedge clk);
    aclr = 1'b1;
  endtask

  task automatic send_one(input int r, input logic [WW-1:0] w);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    req_dig[r*WW +: WW] = w;
    req_valid[r] = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (req_ready[r]) got = 1'b1;
    end
    check("send_grant", got, 1);
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int k;
    k = 0;
    while ((sb_q.size() != 0 || !idle) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check(tag, (k < 100), 1);
  endtask

  initial begin
    #100000;
    check("watchdog", 1, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [WW-1:0] w0;
    logic [NUM_REQ-1:0] exp_en [3];
    logic [NUM_REQ-1:0] acc;
    int seqn [NUM_REQ];
    int gi;
    int base;

    aclr = 1'b0; en = 1'b1; clr = 1'b0; req_valid = '0; req_dig = '0;
    pipe_early = 1'b0;

    // reset values, pipe_aclr held one clock past release
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    aclr = 1'b1;
    #1 check("rst_pipe_aclr_hold", pipe_aclr, 1);
    @(posedge clk); #1;
    check("rst_pipe_aclr_drop", pipe_aclr, 0);

    // single word from requester 2
    w0 = mk(18'h0, 18'hf424, 18'h405a, 18'h1db5c, 18'h3a3d0, 18'h258, 18'h14928, 18'h1108c);
    send_one(2, w0);
    @(negedge clk);
    check("single_busy", idle, 0);
    check("single_dval_in", pipe_dval_in, 1);
    check("single_dig_in", pipe_dig_in, w0);
    wait_drain("single_drain");
    repeat (2) @(negedge clk);
    check("single_idle", idle, 1);
    check("single_count", rsp_cnt, 1);

    // round robin, all four requesters valid for 8 grants
    do_reset();
    @(posedge clk); #1;
    for (int r = 0; r < NUM_REQ; r++) begin
      seqn[r] = 0;
      req_dig[r*WW +: WW] = rrw(r, 0);
    end
    req_valid = '1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("rr_grant", req_ready, 4'b0001 << (c % 4));
      @(posedge clk); #1;
      gi = c % 4;
      seqn[gi]++;
      req_dig[gi*WW +: WW] = rrw(gi, seqn[gi]);
    end
    req_valid = '0;
    base = rsp_cnt;
    wait_drain("rr_drain");
    check("rr_count", rsp_cnt - base, 8);

    // mixed stream from requester 1
    sign_log.delete();
    base = rsp_cnt;
    send_one(1, mk(18'h00001, 18'h1f3a, 18'h2222, 18'h3ffff, 18'h0abc, 18'h1234, 18'h2468, 18'h369c));
    send_one(1, mk(18'h3fffe, 18'h20c5, 18'h1ddd, 18'h00000, 18'h3543, 18'h2dcb, 18'h1b97, 18'h0963));
    send_one(1, WW'(64'd1234567890123456789));
    wait_drain("mix_drain");
    check("mix_count", rsp_cnt - base, 3);
    check("mix_sign_diff", (sign_log[0] != sign_log[1]), 1);

    // en dropped after three grants: requesters 0 and 3 streaming
    do_reset();
    exp_en[0] = 4'b0001; exp_en[1] = 4'b1000; exp_en[2] = 4'b0001;
    base = rsp_cnt;
    @(posedge clk); #1;
    req_dig[0*WW +: WW] = rrw(0, 10);
    req_dig[3*WW +: WW] = rrw(3, 10);
    req_valid = 4'b1001;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("en_grant", req_ready, exp_en[c]);
      @(posedge clk); #1;
      gi = (c == 1) ? 3 : 0;
      req_dig[gi*WW +: WW] = rrw(gi, 11 + c);
      if (c == 2) en = 1'b0;
    end
    acc = '0;
    repeat (6) begin
      @(negedge clk);
      acc = acc | req_ready;
    end
    check("en_blocked", acc, 0);
    wait_drain("en_drain");
    req_valid = '0;
    en = 1'b1;
    check("en_count", rsp_cnt - base, 3);
    while (cyc < last_rsp_cyc + 2) @(negedge clk);
    check("en_idle", idle, 1);

    // pipe reports one clock early
    do_reset();
    pipe_early = 1'b1;
    sb_off = 1'b1;
    send_one(2, w0);
    repeat (16) @(negedge clk);
    check("mis_seq_err", seq_err, 1);
    repeat (5) @(negedge clk);
    check("mis_sticky", seq_err, 1);
    @(posedge clk); #1;
    clr = 1'b1;
    req_valid[0] = 1'b1;
    @(negedge clk);
    check("clr_ready", req_ready, 0);
    @(posedge clk); #1;
    clr = 1'b0;
    req_valid = '0;
    check("clr_pipe_aclr", pipe_aclr, 1);
    check("clr_seq_err", seq_err, 0);
    check("clr_idle", idle, 1);
    check("clr_rsp_valid", rsp_valid, 0);
    @(posedge clk); #1;
    check("clr_pipe_aclr_drop", pipe_aclr, 0);
    pipe_early = 1'b0;
    sb_off = 1'b0;

    // reset with five words in flight
    @(posedge clk); #1;
    for (int r = 0; r < NUM_REQ; r++) req_dig[r*WW +: WW] = rrw(r, 20);
    req_valid = '1;
    repeat (5) @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    check("mid_busy", idle, 0);
    repeat (2) @(negedge clk);
    base = rsp_cnt;
    aclr = 1'b0;
    #1 chk_reset_outputs("mid");
    repeat (2) @(negedge clk);
    aclr = 1'b1;
    repeat (30) @(negedge clk);
    check("mid_no_rsp", rsp_cnt - base, 0);
    check("mid_idle", idle, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/norm_pipe_arbiter.md
Name: norm_pipe_arbiter

Overview:
Round-robin scheduler that shares one Full_Norm_pipe8x18_dval sign-normalization pipeline between NUM_REQ requesters.
- Accepts 8-digit 18-bit RNS words via valid/ready handshakes and issues at most one word per clock into the pipe.
- Tracks the requester ID of every in-flight word in a tag shift register matched to the pipe latency, and returns each result tagged with its ID.
- Supervises pipe alignment, provides soft clear and drain control, and sits between the matrix-multiply product stage and downstream consumers.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- NUM_DIG, 8, digits per RNS word.
- DIG_W, 18, bits per digit.
- PIPE_LAT, 12, clocks from pipe datavalid_in to datavalid_out; must equal the instantiated pipe's latency.
- ID_W, 2, requester ID width, equal to clog2(NUM_REQ).

Ports:
- clk  in  1  system clock, rising edge.
- aclr  in  1  asynchronous active-low reset.
- en  in  1  grant enable; low blocks new grants, in-flight words still drain.
- clr  in  1  synchronous soft clear.
- req_valid  in  NUM_REQ  per-requester word valid.
- req_ready  out  NUM_REQ  per-requester grant, at most one bit high.
- req_dig  in  NUM_REQ*NUM_DIG*DIG_W  packed words; requester r occupies slice r, digit 0 in the LSBs.
- pipe_aclr  out  1  clear pulse to the pipe's aclr (active-high).
- pipe_dval_in  out  1  to pipe datavalid_in.
- pipe_dig_in  out  NUM_DIG*DIG_W  to pipe Dig_0_..Dig_7_.
- pipe_dval_out  in  1  from pipe datavalid_out.
- pipe_dig_out  in  NUM_DIG*DIG_W  from pipe sign_norm_d0_..d7_.
- pipe_sign  in  2  from pipe sign_out.
- rsp_valid  out  1  result valid (one-cycle pulse).
- rsp_id  out  ID_W  requester owning the result.
- rsp_dig  out  NUM_DIG*DIG_W  normalized digits.
- rsp_sign  out  2  sign code.
- idle  out  1  no word in flight.
- seq_err  out  1  sticky alignment error.

Behaviour:
- Reset: aclr low asynchronously clears all state.
  - Output values: req_ready=0, pipe_dval_in=0, pipe_dig_in=0, rsp_valid=0, rsp_id=0, rsp_dig=0, rsp_sign=0, idle=1, seq_err=0, pipe_aclr=1.
  - The round-robin pointer points at requester NUM_REQ-1, so requester 0 has top priority first.
  - pipe_aclr stays high for the first clock after aclr deasserts, then drops.
- Arbitration is combinational.
  - When en=1 and clr=0, req_ready grants the first requester with req_valid=1, searching upward from pointer+1 with wrap-around.
  - On a grant the pointer becomes the granted index at the clock edge.
  - A requester with req_valid=0 never receives ready.
  - Once req_valid is raised, the requester holds it and its data until ready.
- Issue: at a handshake edge T, pipe_dig_in is loaded from the granted slice and pipe_dval_in=1 during T+1.
  - With no grant, pipe_dval_in=0 and pipe_dig_in holds its last value.
- Tag line: PIPE_LAT+1 stages of {valid,id}, entering alongside pipe_dval_in.
  - The last stage aligns with pipe_dval_out, nominally at T+1+PIPE_LAT.
- Response registered one clock later, so handshake-to-rsp_valid latency is PIPE_LAT+2.
  - rsp_valid=pipe_dval_out.
  - rsp_id = last tag id; rsp_dig and rsp_sign are captured from the pipe.
  - No backpressure: the consumer must accept every pulse.
- Mismatch: pipe_dval_out differing from the last tag valid sets seq_err.
  - The result is still forwarded, with rsp_id taken from the tag.
  - seq_err is cleared only by aclr or clr.
- Outstanding counter, width clog2(PIPE_LAT+3):
  - +1 on issue, -1 on rsp_valid; simultaneous events leave it unchanged.
  - idle = (count==0).
- Back-to-back: one grant per clock sustained; a single active requester is granted every cycle.
- en low mid-stream: grants stop next cycle; in-flight results still emerge; idle rises after the last rsp_valid.
- clr=1, synchronous:
  - Forces req_ready=0 that cycle and clears the tag line, counter, seq_err, rsp_valid and pointer.
  - Pulses pipe_aclr for one clock; results in flight are discarded.
  - Any pipe_dval_out within PIPE_LAT+2 clocks after clr is ignored and sets no error.

Test Plan:
- Single word: requester 2 sends {0,f424,405a,1db5c,3a3d0,258,14928,1108c} → rsp_valid exactly PIPE_LAT+2 clocks after the handshake, rsp_id=2, digits equal to a direct pipe run (-129.706…), idle back to 1.
- Round robin: all 4 requesters hold valid for 8 cycles → grants 0,1,2,3,0,1,2,3, one per clock; 8 responses with ids in the same order, back-to-back.
- Mixed stream: requester 1 sends -129.7, +129.7, then integer 1234567890123456789 → rsp_id=1 three times, results in order, the two 129.7 signs differ.
- en deassert: requesters 0 and 3 streaming, en low after 3 grants → no further ready; exactly 3 responses; idle=1 two clocks after the last.
- Misalignment: the bench drives pipe_dval_out one clock early → seq_err=1 and stays high until clr; clr pulses pipe_aclr for one clock, and seq_err=0 and idle=1 the next clock.
- Reset mid-flight: aclr low with 5 words in flight → all outputs at reset values immediately; no rsp_valid afterward.
